afpm_operand_loader: RTL and testbench

// - Upstream stage of the logarithmic approximate FP multiplier (tt_um_logarithmic_afpm).
// - Assembles two 16-bit FP16 operands (A, B) from parallel byte streams, low byte first.
//   A arrives on the ui_in lane and B on the uio_in lane.
// - Presents complete operand pairs to the multiplier core over a valid/ready handshake.
// - Recovers from truncated transfers with an idle timeout, and flags bytes that arrive while it is busy.

---
 rtl/afpm_operand_loader_if.sv | 38 +++
 rtl/afpm_operand_loader.sv | 121 ++++++++++++
 tb/tb_afpm_operand_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/afpm_operand_loader_if.sv
// Byte-stream / operand handshake bundle between the upstream byte source, the operand loader and the multiplier core.
// The a_class/b_class signals exist only when AFPM_CLASSIFY_EN is defined.
interface afpm_operand_loader_if #(
    parameter int DATA_W = 16,
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] byte_a;
    logic [BYTE_W-1:0] byte_b;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              op_ready;
    logic              resync;
    logic              overrun;
`ifdef AFPM_CLASSIFY_EN
    logic [1:0]        a_class;
    logic [1:0]        b_class;
`endif

    // The loader sits on the slave side; the byte source and the core share the master side.
    modport master (
        output byte_a, byte_b, in_valid, op_ready,
`ifdef AFPM_CLASSIFY_EN
        input  a_class, b_class,
`endif
        input  in_ready, op_a, op_b, op_valid, resync, overrun
    );

    modport slave (
        input  byte_a, byte_b, in_valid, op_ready,
`ifdef AFPM_CLASSIFY_EN
        output a_class, b_class,
`endif
        output in_ready, op_a, op_b, op_valid, resync, overrun
    );
endinterface

// File: rtl/afpm_operand_loader.sv
// Assembles FP16 operand pairs from low-byte-first parallel byte lanes and hands them to the multiplier core.
// Optional FP16 class decode of each operand is enabled by defining AFPM_CLASSIFY_EN.
module afpm_operand_loader #(
    parameter int DATA_W      = 16,
    parameter int BYTE_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input logic                  clk,
    input logic                  rst,
    afpm_operand_loader_if.slave bus
);
    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  idle_cnt;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              op_valid_q;
    logic              resync_q;
    logic              overrun_q;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // Operands as they would look once the current byte pair lands in its slice.
    always_comb begin
        next_a = op_a_q;
        next_b = op_b_q;
        next_a[idx*BYTE_W +: BYTE_W] = bus.byte_a;
        next_b[idx*BYTE_W +: BYTE_W] = bus.byte_b;
    end

`ifdef AFPM_CLASSIFY_EN
    logic [1:0] a_class_q;
    logic [1:0] b_class_q;

    // Subnormals are reported as zero because the core flushes them.
    function automatic logic [1:0] fp16_class(input logic [4:0] exp_f, input logic [9:0] man_f);
        if (exp_f == 5'd0)
            return 2'b01;
        else if (exp_f == 5'h1F)
            return (man_f == 10'd0) ? 2'b10 : 2'b11;
        else
            return 2'b00;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            idx        <= '0;
            idle_cnt   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            resync_q   <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef AFPM_CLASSIFY_EN
            a_class_q  <= 2'b00;
            b_class_q  <= 2'b00;
`endif
        end else begin
            resync_q <= 1'b0;
            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        op_a_q   <= next_a;
                        op_b_q   <= next_b;
                        idle_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state      <= FULL;
                            idx        <= '0;
                            op_valid_q <= 1'b1;
`ifdef AFPM_CLASSIFY_EN
                            a_class_q  <= fp16_class(next_a[14:10], next_a[9:0]);
                            b_class_q  <= fp16_class(next_b[14:10], next_b[9:0]);
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (idx != '0 && TIMEOUT_CYC != 0) begin
                        // A stalled partial word is abandoned so the next byte is taken as a low byte.
                        if (idle_cnt == TO_LAST) begin
                            idx      <= '0;
                            idle_cnt <= '0;
                            resync_q <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.in_valid)
                        overrun_q <= 1'b1;
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state      <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready = (state == COLLECT);
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_valid = op_valid_q;
    assign bus.resync   = resync_q;
    assign bus.overrun  = overrun_q;
`ifdef AFPM_CLASSIFY_EN
    assign bus.a_class  = a_class_q;
    assign bus.b_class  = b_class_q;
`endif
endmodule

// File: tb/tb_afpm_operand_loader.sv
// Directed bench for afpm_operand_loader: queue-based behavioural model checked every cycle plus literal spot checks.
// Class outputs are checked when AFPM_CLASSIFY_EN is defined.
module tb_afpm_operand_loader;
    localparam int DATA_W  = 16;
    localparam int BYTE_W  = 8;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    afpm_operand_loader_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) bus ();

    afpm_operand_loader #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: bytes collected so far, the operand pair on offer, and the flags.
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    bit          m_full;
    bit          m_overrun;
    bit          m_resync;
    bit          m_ready_chk = 1'b0;
    int          m_idle;
    logic [15:0] m_op_a;
    logic [15:0] m_op_b;

    function automatic logic [1:0] classOf(input logic [15:0] v);
        logic [4:0] e;
        e = v[14:10];
        if (e == 5'd0) return 2'b01;
        if (e == 5'd31) return (v[9:0] == 10'd0) ? 2'b10 : 2'b11;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            m_full      = 1'b0;
            m_overrun   = 1'b0;
            m_resync    = 1'b0;
            m_idle      = 0;
            m_op_a      = 16'h0;
            m_op_b      = 16'h0;
            m_ready_chk = 1'b1;
        end else begin
            m_resync = 1'b0;
            if (m_full) begin
                if (bus.in_valid) m_overrun = 1'b1;
                if (bus.op_ready) m_full = 1'b0;
            end else if (bus.in_valid) begin
                qa.push_back(bus.byte_a);
                qb.push_back(bus.byte_b);
                m_idle = 0;
                if (qa.size() == DATA_W / BYTE_W) begin
                    m_op_a = {qa[1], qa[0]};
                    m_op_b = {qb[1], qb[0]};
                    qa.delete();
                    qb.delete();
                    m_full = 1'b1;
                end
            end else if (qa.size() != 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    qa.delete();
                    qb.delete();
                    m_idle   = 0;
                    m_resync = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ready_chk) begin
            checkOutput("in_ready", 32'(bus.in_ready), 32'(!m_full));
            checkOutput("op_valid", 32'(bus.op_valid), 32'(m_full));
            checkOutput("resync", 32'(bus.resync), 32'(m_resync));
            checkOutput("overrun", 32'(bus.overrun), 32'(m_overrun));
            if (m_full) begin
                checkOutput("op_a", 32'(bus.op_a), 32'(m_op_a));
                checkOutput("op_b", 32'(bus.op_b), 32'(m_op_b));
`ifdef AFPM_CLASSIFY_EN
                checkOutput("a_class", 32'(bus.a_class), 32'(classOf(m_op_a)));
                checkOutput("b_class", 32'(bus.b_class), 32'(classOf(m_op_b)));
`endif
            end
        end
    end

    // Present one byte pair for exactly one clock edge; returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ready);
        bus.byte_a   = a;
        bus.byte_b   = b;
        bus.in_valid = 1'b1;
        bus.op_ready = ready;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n, input logic ready);
        bus.in_valid = 1'b0;
        bus.op_ready = ready;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetCycles(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.byte_a   = '0;
        bus.byte_b   = '0;
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b0;
        @(posedge clk);
        #1;
        resetCycles(2);
        checkOutput("rst_op_a", 32'(bus.op_a), 32'h0);
        checkOutput("rst_op_b", 32'(bus.op_b), 32'h0);
        checkOutput("rst_valid", 32'(bus.op_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'h0);

        // Case 1: back-to-back bytes, core ready
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput("c1_not_yet", 32'(bus.op_valid), 32'h0);
        applyStimulus(8'h3E, 8'h42, 1'b1);
        checkOutput("c1_valid", 32'(bus.op_valid), 32'h1);
        checkOutput("c1_op_a", 32'(bus.op_a), 32'h3E00);
        checkOutput("c1_op_b", 32'(bus.op_b), 32'h4200);
        checkOutput("c1_in_ready", 32'(bus.in_ready), 32'h0);
        idleCycles(1, 1'b1);
        checkOutput("c1_consumed", 32'(bus.op_valid), 32'h0);
        checkOutput("c1_ready_back", 32'(bus.in_ready), 32'h1);

        // Case 2: core stalls for 5 cycles
        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'h3E, 8'h42, 1'b0);
        idleCycles(5, 1'b0);
        checkOutput("c2_held_valid", 32'(bus.op_valid), 32'h1);
        checkOutput("c2_held_a", 32'(bus.op_a), 32'h3E00);
        checkOutput("c2_in_ready", 32'(bus.in_ready), 32'h0);
        idleCycles(1, 1'b1);
        checkOutput("c2_released", 32'(bus.op_valid), 32'h0);
        checkOutput("c2_ready_back", 32'(bus.in_ready), 32'h1);

        // Case 3: truncated word times out after 15 idle cycles
        applyStimulus(8'h01, 8'h01, 1'b1);
        idleCycles(14, 1'b1);
        checkOutput("c3_no_resync_yet", 32'(bus.resync), 32'h0);
        idleCycles(1, 1'b1);
        checkOutput("c3_resync", 32'(bus.resync), 32'h1);
        idleCycles(1, 1'b1);
        checkOutput("c3_resync_pulse", 32'(bus.resync), 32'h0);
        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'h3E, 8'h42, 1'b0);
        checkOutput("c3_op_a", 32'(bus.op_a), 32'h3E00);
        idleCycles(1, 1'b1);

        // One idle cycle short of the timeout: the word still completes
        applyStimulus(8'h01, 8'h02, 1'b0);
        idleCycles(14, 1'b0);
        applyStimulus(8'h03, 8'h04, 1'b0);
        checkOutput("edge_op_a", 32'(bus.op_a), 32'h0301);
        checkOutput("edge_op_b", 32'(bus.op_b), 32'h0402);
        idleCycles(1, 1'b1);

        // Case 4: bytes arriving while full are dropped and flagged
        applyStimulus(8'h11, 8'h22, 1'b0);
        applyStimulus(8'h33, 8'h44, 1'b0);
        applyStimulus(8'hAA, 8'hBB, 1'b0);
        checkOutput("c4_overrun", 32'(bus.overrun), 32'h1);
        checkOutput("c4_op_a_kept", 32'(bus.op_a), 32'h3311);
        checkOutput("c4_op_b_kept", 32'(bus.op_b), 32'h4422);
        applyStimulus(8'hCC, 8'hDD, 1'b1);
        checkOutput("c4_handshake", 32'(bus.op_valid), 32'h0);
        applyStimulus(8'h55, 8'h66, 1'b0);
        applyStimulus(8'h77, 8'h88, 1'b0);
        checkOutput("c4_next_a", 32'(bus.op_a), 32'h7755);
        checkOutput("c4_sticky", 32'(bus.overrun), 32'h1);
        idleCycles(1, 1'b1);

        // Case 5: reset mid-word, then reset while full
        applyStimulus(8'h01, 8'h01, 1'b1);
        resetCycles(1);
        checkOutput("c5_overrun_clr", 32'(bus.overrun), 32'h0);
        checkOutput("c5_op_a_clr", 32'(bus.op_a), 32'h0);
        checkOutput("c5_resync", 32'(bus.resync), 32'h0);
        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'h3E, 8'h42, 1'b0);
        checkOutput("c5_op_a", 32'(bus.op_a), 32'h3E00);
        resetCycles(1);
        checkOutput("c5_full_drop", 32'(bus.op_valid), 32'h0);
        checkOutput("c5_full_ready", 32'(bus.in_ready), 32'h1);

`ifdef AFPM_CLASSIFY_EN
        // Case 6: FP16 class decode
        applyStimulus(8'h00, 8'h00, 1'b1);
        applyStimulus(8'h00, 8'h7C, 1'b1);
        checkOutput("c6_a0", 32'(bus.a_class), 32'h1);
        checkOutput("c6_b0", 32'(bus.b_class), 32'h2);
        idleCycles(1, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b1);
        applyStimulus(8'h7E, 8'h3C, 1'b1);
        checkOutput("c6_a1", 32'(bus.a_class), 32'h3);
        checkOutput("c6_b1", 32'(bus.b_class), 32'h0);
        idleCycles(1, 1'b1);
        applyStimulus(8'h01, 8'h00, 1'b1);
        applyStimulus(8'h00, 8'h42, 1'b1);
        checkOutput("c6_a2", 32'(bus.a_class), 32'h1);
        checkOutput("c6_b2", 32'(bus.b_class), 32'h0);
        idleCycles(1, 1'b1);
`endif

        idleCycles(2, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
